// File: rtl/i2s_tx.sv
// I2S master transmitter: divides clk down to bck, frames stereo pairs MSB-first
// with the standard one-bit delay after each lrck edge, zero-padding each slot.
module i2s_tx #(
    parameter int WORD_SIZE = 24,
    parameter int SLOT_SIZE = 32,
    parameter int BCK_DIV   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] l_din,
    input  logic [WORD_SIZE-1:0] r_din,
    input  logic                 din_valid,
    output logic                 din_ready,
    output logic                 bck,
    output logic                 lrck,
    output logic                 dout,
    output logic                 underrun
);
    localparam int FRAME = 2 * SLOT_SIZE;
    localparam int BW    = $clog2(FRAME);
    localparam int DW    = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(BCK_DIV - 1);
    localparam logic [BW-1:0] B_LAST   = BW'(FRAME - 1);
    localparam logic [BW-1:0] B_SLOT   = BW'(SLOT_SIZE);

    logic [DW-1:0]        div;
    logic [BW-1:0]        b, b_next;
    logic                 full, full_next;
    logic [WORD_SIZE-1:0] stg_l, stg_r, act_l, act_r;
    logic [WORD_SIZE-1:0] sh_l, sh_r;
    logic                 fall_tick, load, accept, dout_next;

    // bck is still high in the cycle whose edge takes it low
    assign fall_tick = (div == DIV_LAST) && bck;
    assign b_next    = (b == B_LAST) ? '0 : b + 1'b1;
    assign load      = fall_tick && (b == B_LAST);
    assign accept    = din_valid && din_ready;
    // A load in the accept cycle sees the old (empty) staging flag, so the pair stays staged
    assign full_next = accept | (full & ~load);

    always_comb begin
        int bi;
        bi        = int'(b_next);
        sh_l      = '0;
        sh_r      = '0;
        dout_next = 1'b0;
        if (bi >= 1 && bi <= WORD_SIZE) begin
            sh_l      = act_l >> (WORD_SIZE - bi);
            dout_next = sh_l[0];
        end else if (bi >= SLOT_SIZE + 1 && bi <= SLOT_SIZE + WORD_SIZE) begin
            sh_r      = act_r >> (WORD_SIZE - (bi - SLOT_SIZE));
            dout_next = sh_r[0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div       <= '0;
            bck       <= 1'b0;
            b         <= B_LAST;
            lrck      <= 1'b0;
            dout      <= 1'b0;
            underrun  <= 1'b0;
            full      <= 1'b0;
            din_ready <= 1'b1;
            stg_l     <= '0;
            stg_r     <= '0;
            act_l     <= '0;
            act_r     <= '0;
        end else begin
            underrun <= 1'b0;
            if (div == DIV_LAST) begin
                div <= '0;
                bck <= ~bck;
            end else begin
                div <= div + 1'b1;
            end

            if (accept) begin
                stg_l <= l_din;
                stg_r <= r_din;
            end
            full      <= full_next;
            din_ready <= ~full_next;

            if (fall_tick) begin
                b    <= b_next;
                lrck <= (b_next >= B_SLOT);
                dout <= dout_next;
                if (load) begin
                    act_l    <= full ? stg_l : '0;
                    act_r    <= full ? stg_r : '0;
                    underrun <= ~full;
                end
            end
        end
    end
endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx (24/32/2): reset timing, framing, underrun,
// streaming handshake, load/accept collision and mid-frame reset.
module tb_i2s_tx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] l_din = '0;
    logic [23:0] r_din = '0;
    logic        din_valid = 1'b0;
    logic        din_ready, bck, lrck, dout, underrun;

    int compared = 0;
    int mism     = 0;
    int e        = 0;   // posedges since reset release; sampled at negedge
    int n_acc    = 0;
    int sidx     = 0;
    logic stream = 1'b0;

    i2s_tx #(.WORD_SIZE(24), .SLOT_SIZE(32), .BCK_DIV(2)) dut (
        .clk(clk), .rst(rst), .l_din(l_din), .r_din(r_din),
        .din_valid(din_valid), .din_ready(din_ready), .bck(bck),
        .lrck(lrck), .dout(dout), .underrun(underrun)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] pl(input int i);
        return 24'h800001 + 24'(i) * 24'h010101;
    endfunction
    function automatic logic [23:0] pr(input int i);
        return ~pl(i);
    endfunction
    function automatic int ld(input int k);
        return 4 + 256 * k;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clk; in streaming mode, present the next pair after each accept
    task automatic adv();
        logic acc;
        acc = din_valid && din_ready;
        @(negedge clk);
        e++;
        if (acc && stream) begin
            n_acc++;
            sidx++;
            l_din = pl(sidx);
            r_din = pr(sidx);
        end
    endtask

    task automatic goto(input int target);
        while (e < target) adv();
    endtask

    // Walk one whole frame from its load tick, reading dout on bck rises
    task automatic capture(input int k, input logic [23:0] el, input logic [23:0] er,
                           input logic eu, input logic rdy_chk, input string tag);
        logic [23:0] gl, gr;
        int L, pad, lrbad, und, j;
        L = ld(k); gl = '0; gr = '0; pad = 0; lrbad = 0; und = 0;
        goto(L);
        chk({tag, ".und0"}, 32'(underrun), 32'(eu));
        for (int c = 0; c < 256; c++) begin
            goto(L + c);
            if (underrun) und++;
            if (rdy_chk && c == 0) chk({tag, ".rdy_up"}, 32'(din_ready), 32'd1);
            if (rdy_chk && c == 1) chk({tag, ".rdy_dn"}, 32'(din_ready), 32'd0);
            if (c % 4 == 2) begin
                j = c / 4;
                if (lrck !== (j >= 32)) lrbad++;
                if (j >= 1 && j <= 24)       gl = {gl[22:0], dout};
                else if (j >= 33 && j <= 56) gr = {gr[22:0], dout};
                else if (dout !== 1'b0)      pad++;
            end
        end
        chk({tag, ".left"},  32'(gl), 32'(el));
        chk({tag, ".right"}, 32'(gr), 32'(er));
        chk({tag, ".pad"},   32'(pad), 32'd0);
        chk({tag, ".lrck"},  32'(lrbad), 32'd0);
        chk({tag, ".und_n"}, 32'(und), 32'(eu));
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk("rst.bck",  32'(bck), 32'd0);
        chk("rst.lrck", 32'(lrck), 32'd0);
        chk("rst.dout", 32'(dout), 32'd0);
        chk("rst.rdy",  32'(din_ready), 32'd1);
        chk("rst.und",  32'(underrun), 32'd0);
        rst = 1'b0;
        e = 0;
        goto(1); chk("rel.bck1", 32'(bck), 32'd0);
        goto(2); chk("rel.bck2", 32'(bck), 32'd1);
        goto(4);
        chk("rel.bck4",  32'(bck), 32'd0);
        chk("rel.lrck4", 32'(lrck), 32'd0);
        chk("rel.und4",  32'(underrun), 32'd1);
        goto(5); chk("rel.und5", 32'(underrun), 32'd0);

        // single pair staged for frame 1
        goto(10);
        l_din = 24'hA5A5A5; r_din = 24'h5A5A5A; din_valid = 1'b1;
        adv();
        din_valid = 1'b0;
        chk("single.rdy_dn", 32'(din_ready), 32'd0);
        capture(1, 24'hA5A5A5, 24'h5A5A5A, 1'b0, 1'b0, "single");

        // four frames with nothing offered
        for (int k = 2; k < 6; k++) capture(k, 24'h0, 24'h0, 1'b1, 1'b0, "undr");

        // streaming: pair i plays in frame 7+i
        goto(ld(6) + 8);
        sidx = 0; l_din = pl(0); r_din = pr(0); din_valid = 1'b1; stream = 1'b1;
        for (int i = 0; i < 8; i++) capture(7 + i, pl(i), pr(i), 1'b0, 1'b1, "strm");
        stream = 1'b0; din_valid = 1'b0;
        chk("strm.accepts", 32'(n_acc), 32'd9);
        capture(15, pl(8), pr(8), 1'b0, 1'b0, "strm_last");

        // collision: first valid lands on the load edge with staging empty
        goto(ld(16) - 1);
        l_din = 24'h123456; r_din = 24'hFEDCBA; din_valid = 1'b1;
        adv();
        din_valid = 1'b0;
        chk("coll.rdy", 32'(din_ready), 32'd0);
        capture(16, 24'h0, 24'h0, 1'b1, 1'b0, "coll_z");
        capture(17, 24'h123456, 24'hFEDCBA, 1'b0, 1'b0, "coll_p");

        // mid-frame reset with a pair staged
        goto(ld(18) + 4);
        l_din = 24'h0F0F0F; r_din = 24'hF0F0F0; din_valid = 1'b1;
        adv();
        din_valid = 1'b0;
        chk("mrst.staged", 32'(din_ready), 32'd0);
        goto(ld(18) + 160);
        chk("mrst.lrck_pre", 32'(lrck), 32'd1);
        rst = 1'b1;
        #1;
        chk("mrst.bck",  32'(bck), 32'd0);
        chk("mrst.lrck", 32'(lrck), 32'd0);
        chk("mrst.dout", 32'(dout), 32'd0);
        chk("mrst.rdy",  32'(din_ready), 32'd1);
        chk("mrst.und",  32'(underrun), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        e = 0;
        goto(1); chk("mrst.bck1", 32'(bck), 32'd0);
        goto(2); chk("mrst.bck2", 32'(bck), 32'd1);
        capture(0, 24'h0, 24'h0, 1'b1, 1'b0, "mrst_f0");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end
endmodule
